// File: rtl/rf_writeback_queue.sv
// In-order write-back FIFO feeding the register-file write port (A3/WD/WE), draining one entry per cycle.
// Define RF_WBQ_BYPASS_EN to enable rs1/rs2 read-bypass of still-pending writes.
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic [31:0]      in_data,
  output logic [4:0]       A3,
  output logic [31:0]      WD,
  output logic             WE,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic             rs1_hit,
  output logic [31:0]      rs1_data,
  output logic             rs2_hit,
  output logic [31:0]      rs2_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [4:0]       rd_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push;
  logic             store;
  logic             pop;

  assign count    = cnt;
  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_W'(DEPTH));
  assign in_ready = !full;

  // Writes to x0 complete the handshake but are dropped before reaching storage.
  assign push  = in_valid && in_ready;
  assign store = push && (in_rd != 5'd0);
  assign pop   = !empty;

  assign WE = !empty;
  assign A3 = empty ? 5'd0  : rd_mem[rd_ptr];
  assign WD = empty ? 32'd0 : data_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CNT_W'(store) - CNT_W'(pop);
    end
  end

  // Storage carries no reset; validity comes solely from the pointers and count.
  always_ff @(posedge clk) begin
    if (rst && store) begin
      rd_mem[wr_ptr]   <= in_rd;
      data_mem[wr_ptr] <= in_data;
    end
  end

`ifdef RF_WBQ_BYPASS_EN
  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    rs1_hit  = 1'b0;
    rs1_data = 32'd0;
    rs2_hit  = 1'b0;
    rs2_data = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < cnt) begin
        if ((rs1_addr != 5'd0) && (rd_mem[rd_ptr + PTR_W'(i)] == rs1_addr)) begin
          rs1_hit  = 1'b1;
          rs1_data = data_mem[rd_ptr + PTR_W'(i)];
        end
        if ((rs2_addr != 5'd0) && (rd_mem[rd_ptr + PTR_W'(i)] == rs2_addr)) begin
          rs2_hit  = 1'b1;
          rs2_data = data_mem[rd_ptr + PTR_W'(i)];
        end
      end
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{rs1_addr, rs2_addr};
  assign rs1_hit  = 1'b0;
  assign rs1_data = 32'd0;
  assign rs2_hit  = 1'b0;
  assign rs2_data = 32'd0;
`endif

endmodule
